// File: rtl/quant_mac.sv
// ============================================================================
// quant_mac : one-cycle fused multiply-add for fp16 and int4/int8/int16 lanes
// Optional build macro: MAC_SAT_EN (saturate integer results instead of wrap)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module quant_mac (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  mode,
  input  logic [15:0] value,
  input  logic [15:0] weight,
  input  logic [23:0] ints,
  input  logic [30:0] fps,
  output logic [23:0] intr,
  output logic [30:0] fpr,
  output logic        out_valid
);

  localparam logic [3:0] MODE_FP    = 4'b0001;
  localparam logic [3:0] MODE_INT_S = 4'b0010;
  localparam logic [3:0] MODE_INT_M = 4'b0100;
  localparam logic [3:0] MODE_INT_L = 4'b1000;

  logic [23:0]        intr_q, intr_d;
  logic [30:0]        fpr_q, fpr_d;
  logic               valid_q, valid_d;

  logic signed [33:0] int_full;
  logic [23:0]        int_res;

  always_comb begin
    int_full = 34'(signed'(ints));
    case (mode)
      MODE_INT_S: begin
        for (int k = 0; k < 4; k++) begin
          int_full = int_full + 34'(8'(signed'(value[4*k +: 4])) *
                                    8'(signed'(weight[4*k +: 4])));
        end
      end
      MODE_INT_M: begin
        for (int k = 0; k < 2; k++) begin
          int_full = int_full + 34'(16'(signed'(value[8*k +: 8])) *
                                    16'(signed'(weight[8*k +: 8])));
        end
      end
      MODE_INT_L: int_full = int_full + 34'(32'(signed'(value)) * 32'(signed'(weight)));
      default: ;
    endcase
  end

`ifdef MAC_SAT_EN
  always_comb begin
    if (int_full > 34'sd8388607)
      int_res = 24'h7FFFFF;
    else if (int_full < -34'sd8388608)
      int_res = 24'h800000;
    else
      int_res = int_full[23:0];
  end
`else
  logic unused_int_hi;
  assign unused_int_hi = ^int_full[33:24];
  assign int_res       = int_full[23:0];
`endif

  logic        sp, p_zero, p_inf;
  logic [4:0]  ea, eb;
  logic [21:0] mprod;
  logic [5:0]  pe, ce;
  logic [23:0] pf;
  logic [24:0] pm, cm;
  logic        big_s, sml_s;
  logic [5:0]  big_e, sml_e, dexp;
  logic [24:0] big_m, sml_m, sml_sh;
  logic [25:0] fsum;
  logic [4:0]  lead, shamt;
  logic [23:0] norm;
  logic [6:0]  rexp;
  logic [30:0] fp_res;

  always_comb begin
    sp     = value[15] ^ weight[15];
    ea     = value[14:10];
    eb     = weight[14:10];
    p_zero = (ea == 5'd0) || (eb == 5'd0);
    p_inf  = (ea == 5'd31) || (eb == 5'd31);
    mprod  = 22'({1'b1, value[9:0]}) * 22'({1'b1, weight[9:0]});
    // Exponent rebias: ea + eb - 30 + 31, plus one more when the product carries.
    pe     = 6'(ea) + 6'(eb) + (mprod[21] ? 6'd2 : 6'd1);
    pf     = mprod[21] ? {mprod[20:0], 3'b0} : {mprod[19:0], 4'b0};
    if (p_zero) begin
      pe = 6'd0;
      pm = 25'd0;
    end else begin
      pm = {1'b1, pf};
    end
    ce = fps[29:24];
    cm = (ce == 6'd0) ? 25'd0 : {1'b1, fps[23:0]};

    if ({pe, pm} >= {ce, cm}) begin
      big_s = sp;      big_e = pe; big_m = pm;
      sml_s = fps[30]; sml_e = ce; sml_m = cm;
    end else begin
      big_s = fps[30]; big_e = ce; big_m = cm;
      sml_s = sp;      sml_e = pe; sml_m = pm;
    end

    dexp   = big_e - sml_e;
    sml_sh = sml_m >> dexp;
    fsum   = (big_s ^ sml_s) ? (26'(big_m) - 26'(sml_sh)) : (26'(big_m) + 26'(sml_sh));

    lead = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (fsum[i]) lead = 5'(i);
    end
    shamt = 5'd24 - lead;

    if (lead == 5'd25) begin
      rexp = 7'(big_e) + 7'd1;
      norm = fsum[24:1];
    end else begin
      rexp = 7'(big_e) - 7'(shamt);
      norm = 24'(fsum[24:0] << shamt);
    end

    if (p_inf)
      fp_res = {sp, 30'h3FFFFFFF};
    else if (fsum == 26'd0)
      fp_res = 31'h0;
    else if ((lead != 5'd25) && ({1'b0, shamt} >= big_e))
      fp_res = 31'h0;
    else if (rexp > 7'd63)
      fp_res = {big_s, 30'h3FFFFFFF};
    else
      fp_res = {big_s, rexp[5:0], norm};
  end

  always_comb begin
    intr_d  = intr_q;
    fpr_d   = fpr_q;
    valid_d = in_valid;
    if (in_valid) begin
      case (mode)
        MODE_FP: begin
          intr_d = 24'h0;
          fpr_d  = fp_res;
        end
        MODE_INT_S, MODE_INT_M, MODE_INT_L: begin
          intr_d = int_res;
          fpr_d  = 31'h0;
        end
        default: begin
          intr_d = 24'h0;
          fpr_d  = 31'h0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_q  <= 24'h0;
      fpr_q   <= 31'h0;
      valid_q <= 1'b0;
    end else begin
      intr_q  <= intr_d;
      fpr_q   <= fpr_d;
      valid_q <= valid_d;
    end
  end

  assign intr      = intr_q;
  assign fpr       = fpr_q;
  assign out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_quant_mac.sv
// ============================================================================
// tb_quant_mac : vector table + scoreboard bench for quant_mac
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_quant_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  mode = 4'b0;
  logic [15:0] value = 16'h0;
  logic [15:0] weight = 16'h0;
  logic [23:0] ints = 24'h0;
  logic [30:0] fps = 31'h0;
  logic [23:0] intr;
  logic [30:0] fpr;
  logic        out_valid;

  quant_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .value     (value),
    .weight    (weight),
    .ints      (ints),
    .fps       (fps),
    .intr      (intr),
    .fpr       (fpr),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mode;
    logic [15:0] value;
    logic [15:0] weight;
    logic [23:0] ints;
    logic [30:0] fps;
    logic [23:0] intr;
    logic [30:0] fpr;
  } vec_t;

  localparam logic [3:0] F = 4'b0001;
  localparam logic [3:0] S = 4'b0010;
  localparam logic [3:0] M = 4'b0100;
  localparam logic [3:0] L = 4'b1000;

`ifdef MAC_SAT_EN
  localparam logic [23:0] EXP_L_POS = 24'h7FFFFF;
  localparam logic [23:0] EXP_L_NEG = 24'h800000;
  localparam logic [23:0] EXP_M_POS = 24'h7FFFFF;
`else
  localparam logic [23:0] EXP_L_POS = 24'hFF0001;
  localparam logic [23:0] EXP_L_NEG = 24'h008000;
  localparam logic [23:0] EXP_M_POS = 24'h807FFF;
`endif

  int n_pass  = 0;
  int n_total = 0;

  vec_t        vecs[18];
  vec_t        exp_q[$];
  logic [23:0] held_intr = 24'h0;
  logic [30:0] held_fpr  = 31'h0;

  function automatic vec_t mk(input logic [3:0] m, input logic [15:0] v, input logic [15:0] w,
                              input logic [23:0] i, input logic [30:0] f,
                              input logic [23:0] ei, input logic [30:0] ef);
    vec_t r;
    r.mode = m; r.value = v; r.weight = w; r.ints = i; r.fps = f; r.intr = ei; r.fpr = ef;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic step(input vec_t v, input logic vld, input string tag);
    vec_t e;
    @(negedge clk);
    mode = v.mode; value = v.value; weight = v.weight; ints = v.ints; fps = v.fps;
    in_valid = vld;
    if (vld) exp_q.push_back(v);
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'(vld));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL %s.sb: result with empty scoreboard", tag);
      end else begin
        e = exp_q.pop_front();
        chk({tag, ".intr"}, 32'(intr), 32'(e.intr));
        chk({tag, ".fpr"},  32'(fpr),  32'(e.fpr));
        held_intr = e.intr;
        held_fpr  = e.fpr;
      end
    end else begin
      chk({tag, ".intr_hold"}, 32'(intr), 32'(held_intr));
      chk({tag, ".fpr_hold"},  32'(fpr),  32'(held_fpr));
    end
  endtask

  initial begin
    vecs[0]  = mk(M, 16'h0203, 16'h0405, 24'h000010, 31'h0,        24'h000027, 31'h0);
    vecs[1]  = mk(S, 16'hF121, 16'h2222, 24'h000000, 31'h0,        24'h000006, 31'h0);
    vecs[2]  = mk(L, 16'h7FFF, 16'h7FFF, 24'h000000, 31'h0,        EXP_L_POS,  31'h0);
    vecs[3]  = mk(F, 16'h3C00, 16'h4000, 24'h000123, 31'h0,        24'h0,      31'h20000000);
    vecs[4]  = mk(F, 16'h3C00, 16'h4000, 24'h000000, 31'h1F000000, 24'h0,      31'h20800000);
    vecs[5]  = mk(M, 16'hFF80, 16'h0102, 24'h000000, 31'h0,        24'hFFFEFF, 31'h0);
    vecs[6]  = mk(L, 16'h8000, 16'h0002, 24'h000100, 31'h0,        24'hFF0100, 31'h0);
    vecs[7]  = mk(L, 16'h8000, 16'h7FFF, 24'h000000, 31'h0,        EXP_L_NEG,  31'h0);
    vecs[8]  = mk(F, 16'h3C00, 16'h4000, 24'h000000, 31'h5F000000, 24'h0,      31'h1F000000);
    vecs[9]  = mk(F, 16'h3C00, 16'h4000, 24'h000000, 31'h60000000, 24'h0,      31'h0);
    vecs[10] = mk(F, 16'h7C00, 16'hC000, 24'h000000, 31'h0,        24'h0,      31'h7FFFFFFF);
    vecs[11] = mk(F, 16'h0000, 16'h4000, 24'h000000, 31'h1F000000, 24'h0,      31'h1F000000);
    vecs[12] = mk(F, 16'h7BFF, 16'h7BFF, 24'h000000, 31'h3F800000, 24'h0,      31'h3FFFFFFF);
    vecs[13] = mk(F, 16'h0400, 16'h0400, 24'h000000, 31'h43000001, 24'h0,      31'h0);
    vecs[14] = mk(4'b0011, 16'h1234, 16'h5678, 24'h000055, 31'h1F000000, 24'h0, 31'h0);
    vecs[15] = mk(S, 16'h8888, 16'h8888, 24'hFFFFF0, 31'h0,        24'h0000F0, 31'h0);
    vecs[16] = mk(M, 16'h8080, 16'h8080, 24'h7FFFFF, 31'h0,        EXP_M_POS,  31'h0);
    vecs[17] = mk(4'b0000, 16'hFFFF, 16'hFFFF, 24'h000001, 31'h1F000000, 24'h0, 31'h0);

    #1 rst_n = 1'b0;
    #1;
    chk("reset.intr",  32'(intr),      32'h0);
    chk("reset.fpr",   32'(fpr),       32'h0);
    chk("reset.valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back vectors, mode switching every cycle.
    for (int i = 0; i < 18; i++) step(vecs[i], 1'b1, $sformatf("v%0d", i));

    // A bubble must drop out_valid and hold the last result.
    step(vecs[1], 1'b1, "hold_pre");
    step(vecs[2], 1'b0, "hold");
    step(vecs[2], 1'b0, "hold2");
    step(vecs[4], 1'b1, "hold_post");

    // Asynchronous reset mid-cycle with an operand pending.
    step(vecs[0], 1'b1, "rst_pre");
    @(negedge clk);
    mode = vecs[5].mode; value = vecs[5].value; weight = vecs[5].weight;
    ints = vecs[5].ints; fps = vecs[5].fps; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async.intr",  32'(intr),      32'h0);
    chk("rst_async.fpr",   32'(fpr),       32'h0);
    chk("rst_async.valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_held.valid", 32'(out_valid), 32'h0);
    chk("rst_held.intr",  32'(intr),      32'h0);
    @(negedge clk);
    in_valid  = 1'b0;
    rst_n     = 1'b1;
    held_intr = 24'h0;
    held_fpr  = 31'h0;
    exp_q.delete();
    step(vecs[5], 1'b0, "rst_idle");
    step(vecs[6], 1'b1, "rst_resume");

    @(negedge clk);
    in_valid = 1'b0;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL sb.drain: %0d results never produced, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/quant_mac.md
# quant_mac

Single-cycle-latency multiply-accumulate datapath for the quantized inference engine. Computes one fused multiply-add per enabled cycle in one of four one-hot modes: a single fp16 product, or four int4, two int8 or one int16 dot-product lanes. Each product is added to an incoming bias or partial sum. It sits between the operand fetch stage and the accumulator buffer, and its result feeds back as the next bias.

## Interface
- No parameters; all widths fixed.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid this cycle.
- mode  input  4  one-hot operating mode:
  - bit0 = fp16
  - bit1 = int_s (4×int4)
  - bit2 = int_m (2×int8)
  - bit3 = int_l (1×int16)
- value  input  16  activation operand.
- weight  input  16  weight operand.
- ints  input  24  signed two's-complement integer bias.
- fps  input  31  extended-float bias: sign[30], exp[29:24] (bias 31), frac[23:0] (hidden 1).
- intr  output  24  signed integer result.
- fpr  output  31  extended-float result, same format as fps.
- out_valid  output  1  intr/fpr valid.

## Operation
- **int_s**
  - Four signed 4-bit lanes per operand, lane k = bits [4k+3:4k].
  - intr = Σ value_k·weight_k + ints.
- **int_m**
  - Two signed 8-bit lanes per operand.
  - intr = Σ products + ints.
- **int_l**
  - intr = signed 16×16 product (32-bit) + sign-extended ints.
- **Integer arithmetic**
  - Computed at ≥34 bits, then reduced to 24 bits; see Configuration.
  - fpr = 0 in all integer modes.
- **fp16 mode: product**
  - value and weight are IEEE half precision.
  - Operand exp field 0 (zero or subnormal) is treated as zero.
  - Operand exp field 31 (inf/NaN) gives a saturated result: fpr = {sign_p, 30'h3FFFFFFF}.
  - Product: sign = sa^sb; exp = ea+eb−30+31; 11×11 mantissa product normalized to 24-bit frac. Exact, no rounding.
- **fp16 mode: accumulate**
  - fps exp field 0 means zero.
  - Align the smaller operand by right shift, truncating shifted-out bits.
  - Add or subtract magnitudes; sign follows the larger magnitude.
  - Normalize, then truncate frac to 24 bits (round toward zero).
  - Exact cancellation gives +0 (31'h0).
  - Result exp >63 saturates to {sign, 30'h3FFFFFFF]; exp <1 flushes to 0.
  - intr = 0 in fp mode.
- **Illegal mode** (zero or more than one bit set): intr = 0, fpr = 0; out_valid still follows in_valid.

## Timing
- **Reset** (rst_n low, asynchronous): intr = 0, fpr = 0, out_valid = 0. Held until rst_n deasserts.
- **Latency**: 1 cycle. Inputs sampled at edge N with in_valid = 1; intr/fpr/out_valid update at edge N. Results are visible in cycle N+1.
- **in_valid = 0**: out_valid = 0 next cycle; intr/fpr hold their previous values.
- **No backpressure**: one result per cycle, fully pipelined.
- **Mode change** between back-to-back cycles takes effect immediately, with no bubble.
- **Reset mid-operation**: the in-flight result is discarded; the first post-reset result needs a new in_valid.

## Configuration
- **MAC_SAT_EN defined**
  - Integer results outside [−2^23, 2^23−1] clamp to 24'h7FFFFF or 24'h800000.
  - fp overflow saturates as specified.
- **MAC_SAT_EN undefined**
  - Integer results wrap: intr = low 24 bits of the full sum.
  - fp behaviour unchanged.

## Test plan
- int_m, value=16'h0203, weight=16'h0405, ints=24'h000010 -> intr=24'h000027, fpr=0, out_valid=1 one cycle later.
- int_s, value=16'hF121, weight=16'h2222, ints=0 -> intr=24'h000006.
- int_l, value=16'h7FFF, weight=16'h7FFF, ints=0 -> intr=24'h7FFFFF with MAC_SAT_EN; 24'hFF0001 without.
- fp, value=16'h3C00, weight=16'h4000:
  - fps=0 -> fpr=31'h20000000.
  - fps=31'h1F000000 (1.0) -> fpr=31'h20800000 (3.0).
- mode=4'b0011 -> intr=0, fpr=0; then rst_n pulsed low mid-stream -> intr=0, fpr=0, out_valid=0 immediately, without waiting for a clock edge.
